seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 143 ++++++++++++++
 tb/tb_seq_alu.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops, bit-serial shifts.
// Optional SEQ_ALU_OVERFLOW_EN adds a registered signed-overflow flag.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
`ifdef SEQ_ALU_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             illegal
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    // Only log2(WIDTH) shamt bits matter; the counter stays 5 bits wide.
    localparam logic [4:0] KMASK = 5'(WIDTH - 1);

    state_t           state, next;
    logic [4:0]       cnt;
    logic [4:0]       cnt_next;
    logic [4:0]       k;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] sh_next;
    logic             dir;
    logic             is_shift;
    logic             accept;
    logic             go_shift;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
`ifdef SEQ_ALU_OVERFLOW_EN
    logic             alu_ovf;
`endif

    assign k        = shamt & KMASK;
    assign is_shift = (ctrl == 4'b0100) || (ctrl == 4'b0101);
    assign accept   = start && (state != SHIFT);
    assign go_shift = accept && is_shift && (k != 5'd0);
    assign sum      = a + b;
    assign diff     = a - b;
    assign cnt_next = cnt - 5'd1;
    assign sh_next  = dir ? {1'b0, shreg[WIDTH-1:1]}
                          : {shreg[WIDTH-2:0], 1'b0};
    assign busy     = (state == SHIFT);
    assign done     = (state == FIN);

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        unique case (ctrl)
            4'b0000: alu_res = a & b;
            4'b0001: alu_res = a | b;
            4'b0010: alu_res = sum;
            4'b0011: alu_res = diff;
            // zero-length shifts complete at once with the source unchanged
            4'b0100: alu_res = b;
            4'b0101: alu_res = b;
            4'b0110: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            default: alu_ill = 1'b1;
        endcase
    end

`ifdef SEQ_ALU_OVERFLOW_EN
    always_comb begin
        alu_ovf = 1'b0;
        if (ctrl == 4'b0010)
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        else if (ctrl == 4'b0011)
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE, FIN: begin
                if (accept) next = go_shift ? SHIFT : FIN;
                else        next = IDLE;
            end
            SHIFT:   if (cnt_next == 5'd0) next = FIN;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result   <= '0;
            zero     <= 1'b1;
            illegal  <= 1'b0;
            cnt      <= 5'd0;
            shreg    <= '0;
            dir      <= 1'b0;
`ifdef SEQ_ALU_OVERFLOW_EN
            overflow <= 1'b0;
`endif
        end else if (state == SHIFT) begin
            shreg <= sh_next;
            cnt   <= cnt_next;
            if (cnt_next == 5'd0) begin
                result   <= sh_next;
                zero     <= (sh_next == '0);
                illegal  <= 1'b0;
`ifdef SEQ_ALU_OVERFLOW_EN
                overflow <= 1'b0;
`endif
            end
        end else if (accept) begin
            if (go_shift) begin
                shreg <= b;
                cnt   <= k;
                dir   <= ctrl[0];
            end else begin
                result   <= alu_res;
                zero     <= (alu_res == '0);
                illegal  <= alu_ill;
`ifdef SEQ_ALU_OVERFLOW_EN
                overflow <= alu_ovf;
`endif
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed vectors queued at issue,
// checked by a monitor whenever done is presented.
module tb_seq_alu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        zero;
    logic        busy;
    logic        done;
    logic        illegal;
`ifdef SEQ_ALU_OVERFLOW_EN
    logic        overflow;
`endif

    seq_alu #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ctrl     (ctrl),
        .a        (a),
        .b        (b),
        .shamt    (shamt),
        .result   (result),
        .zero     (zero),
        .busy     (busy),
        .done     (done),
`ifdef SEQ_ALU_OVERFLOW_EN
        .overflow (overflow),
`endif
        .illegal  (illegal)
    );

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        z;
        logic        ill;
        logic        ov;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   ncmp = 0;
    int   nerr = 0;
    int   cyc  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                ncmp++;
                nerr++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, ".result"}, result, e.res);
                chk({e.name, ".zero"}, 32'(zero), 32'(e.z));
                chk({e.name, ".illegal"}, 32'(illegal), 32'(e.ill));
                chk({e.name, ".cycle"}, cyc, e.cyc);
`ifdef SEQ_ALU_OVERFLOW_EN
                chk({e.name, ".overflow"}, 32'(overflow), 32'(e.ov));
`endif
            end
        end
    end

    // Drive one request on a falling edge; the expectation records the
    // cycle in which done should be seen (one cycle, plus k for shifts).
    task automatic issue(input string nm, input logic [3:0] c,
                         input logic [31:0] va, input logic [31:0] vb,
                         input logic [4:0] sa, input logic [31:0] er,
                         input logic ei, input logic eo, input int k);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        ctrl  = c;
        a     = va;
        b     = vb;
        shamt = sa;
        e.name = nm;
        e.res  = er;
        e.z    = (er == 32'd0);
        e.ill  = ei;
        e.ov   = eo;
        e.cyc  = cyc + 1 + k;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        ctrl  = 4'd0;
        a     = '0;
        b     = '0;
        shamt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset.result", result, 32'd0);
        chk("reset.zero", 32'(zero), 32'd1);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.illegal", 32'(illegal), 32'd0);

        issue("add", 4'b0010, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0, 1'b0, 0);
        idle(1);
        chk("add.busy", 32'(busy), 32'd0);
        idle(2);
        chk("hold.result", result, 32'd12);

        issue("sub_zero", 4'b0011, 32'd9, 32'd9, 5'd0, 32'd0, 1'b0, 1'b0, 0);
        idle(2);
        issue("slt", 4'b0110, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 1'b0, 1'b0, 0);
        idle(2);
        issue("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd2, 5'd0, 32'd1, 1'b0, 1'b0, 0);
        idle(2);

        issue("sll4", 4'b0100, 32'hDEAD_0000, 32'h0000_0001, 5'd4,
              32'h0000_0010, 1'b0, 1'b0, 4);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("sll4.busy%0d", i), 32'(busy), 32'd1);
            start = (i == 2 || i == 4);
            ctrl  = 4'b0010;
            a     = 32'd1;
            b     = 32'hFFFF_FFFF;
            shamt = 5'd31;
        end
        idle(1);
        chk("sll4.busy_end", 32'(busy), 32'd0);
        idle(2);

        issue("srl4", 4'b0101, 32'd0, 32'h0000_00F0, 5'd4,
              32'h0000_000F, 1'b0, 1'b0, 4);
        @(negedge clk);
        start = 1'b0;
        ctrl  = 4'b0100;
        b     = 32'h1234_5678;
        shamt = 5'd1;
        idle(6);

        issue("sll0", 4'b0100, 32'd0, 32'h0000_00A5, 5'd0,
              32'h0000_00A5, 1'b0, 1'b0, 0);
        idle(2);

        // Long shift aborted by reset: its expectation is withdrawn.
        issue("srl31", 4'b0101, 32'd0, 32'h8000_0000, 5'd31, 32'd1, 1'b0, 1'b0, 31);
        void'(q.pop_back());
        idle(9);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        ctrl  = 4'b0010;
        a     = 32'd1;
        b     = 32'd1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk("abort.result", result, 32'd0);
        chk("abort.zero", 32'(zero), 32'd1);
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        idle(1);
        issue("or", 4'b0001, 32'h0000_00F0, 32'h0000_000F, 5'd0,
              32'h0000_00FF, 1'b0, 1'b0, 0);
        idle(2);

        issue("illegal", 4'b1010, 32'h1234_5678, 32'h1, 5'd0, 32'd0, 1'b1, 1'b0, 0);
        issue("and_b2b", 4'b0000, 32'h0000_FF00, 32'h0000_0FF0, 5'd0,
              32'h0000_0F00, 1'b0, 1'b0, 0);
        idle(2);

        issue("ovf_add", 4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd0,
              32'h8000_0000, 1'b0, 1'b1, 0);
        issue("ovf_sub", 4'b0011, 32'h8000_0000, 32'd1, 5'd0,
              32'h7FFF_FFFF, 1'b0, 1'b1, 0);
        issue("add_noovf", 4'b0010, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0, 1'b0, 0);
        idle(5);

        chk("pending", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
